// File: rtl/txn_dispatcher.sv
// Transaction dispatcher: assigns free executor slots, tracks in-flight dependency masks.
// Optional per-slot watchdog enabled by defining TXN_DISPATCHER_WATCHDOG_EN.
module txn_dispatcher #(
  parameter int unsigned MAX_DEPENDENCIES = 256,
  parameter int unsigned NUM_SLOTS        = 4,
  parameter int unsigned SLOT_W           = 2,
  parameter int unsigned TIMEOUT_CYCLES   = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [63:0]                 s_axis_tdata_owner_programID,
  input  logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_read_dependencies,
  input  logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_write_dependencies,
  output logic                        exec_valid,
  input  logic                        exec_ready,
  output logic [SLOT_W-1:0]           exec_slot,
  output logic [63:0]                 exec_programID,
  input  logic                        cmpl_valid,
  input  logic [SLOT_W-1:0]           cmpl_slot,
  output logic [MAX_DEPENDENCIES-1:0] locked_read_mask,
  output logic [MAX_DEPENDENCIES-1:0] locked_write_mask,
  output logic [31:0]                 inflight_count,
  output logic [31:0]                 dispatched_total,
  output logic                        err_spurious_cmpl
`ifdef TXN_DISPATCHER_WATCHDOG_EN
  ,
  output logic                        watchdog_fire,
  output logic [SLOT_W-1:0]           watchdog_slot
`endif
);

  if (SLOT_W != $clog2(NUM_SLOTS) || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("txn_dispatcher: SLOT_W must equal clog2(NUM_SLOTS), TIMEOUT_CYCLES must be nonzero");
  end

  typedef enum logic [0:0] {StIdle, StDispatch} state_e;

  state_e                      state_q, state_d;
  logic [NUM_SLOTS-1:0]        busy_q, busy_d;
  logic [MAX_DEPENDENCIES-1:0] rd_mask_q [NUM_SLOTS];
  logic [MAX_DEPENDENCIES-1:0] rd_mask_d [NUM_SLOTS];
  logic [MAX_DEPENDENCIES-1:0] wr_mask_q [NUM_SLOTS];
  logic [MAX_DEPENDENCIES-1:0] wr_mask_d [NUM_SLOTS];
  logic [SLOT_W-1:0]           exec_slot_q, exec_slot_d;
  logic [63:0]                 exec_pid_q, exec_pid_d;
  logic [31:0]                 inflight_q, inflight_d;
  logic [31:0]                 total_q, total_d;
  logic                        err_q, err_d;

  logic              alloc_found;
  logic [SLOT_W-1:0] alloc_slot;
  logic              accept;
  logic              cmpl_in_range;
  logic              cmpl_hits_pending;
  logic              cmpl_ok;
  logic              wd_fire;
  logic [SLOT_W-1:0] wd_slot;

  // Lowest-index free slot, taken from the pre-edge busy vector.
  always_comb begin
    alloc_found = 1'b0;
    alloc_slot  = '0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      if (!busy_q[i] && !alloc_found) begin
        alloc_found = 1'b1;
        alloc_slot  = SLOT_W'(i);
      end
    end
  end

  assign s_axis_tready = (state_q == StIdle) && alloc_found;
  assign accept        = s_axis_tvalid && s_axis_tready;

  // A slot still waiting on the dispatch handshake cannot be completed yet.
  assign cmpl_in_range     = 32'(cmpl_slot) < NUM_SLOTS;
  assign cmpl_hits_pending = (state_q == StDispatch) && (cmpl_slot == exec_slot_q);
  assign cmpl_ok           = cmpl_valid && cmpl_in_range && busy_q[cmpl_slot] &&
                             !cmpl_hits_pending;

`ifdef TXN_DISPATCHER_WATCHDOG_EN
  localparam int unsigned AgeW = $clog2(TIMEOUT_CYCLES + 1);

  logic [AgeW-1:0]      age_q [NUM_SLOTS];
  logic [AgeW-1:0]      age_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] armed;
  logic [NUM_SLOTS-1:0] expired;

  always_comb begin
    wd_fire = 1'b0;
    wd_slot = '0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      armed[i]   = busy_q[i] && !((state_q == StDispatch) && (exec_slot_q == SLOT_W'(i)));
      // A completion landing on the timeout cycle wins over the watchdog.
      expired[i] = armed[i] && (age_q[i] == AgeW'(TIMEOUT_CYCLES)) &&
                   !(cmpl_ok && (cmpl_slot == SLOT_W'(i)));
      if (!armed[i]) begin
        age_d[i] = '0;
      end else if (age_q[i] < AgeW'(TIMEOUT_CYCLES)) begin
        age_d[i] = age_q[i] + AgeW'(1);
      end else begin
        age_d[i] = age_q[i];
      end
      // One slot freed per cycle; other expired slots saturate and fire later.
      if (expired[i] && !wd_fire) begin
        wd_fire = 1'b1;
        wd_slot = SLOT_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) age_q[i] <= age_d[i];
    end
  end

  assign watchdog_fire = wd_fire;
  assign watchdog_slot = wd_slot;
`else
  assign wd_fire = 1'b0;
  assign wd_slot = '0;
`endif

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    rd_mask_d   = rd_mask_q;
    wr_mask_d   = wr_mask_q;
    exec_slot_d = exec_slot_q;
    exec_pid_d  = exec_pid_q;
    total_d     = total_q;
    err_d       = err_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d     = StDispatch;
          exec_slot_d = alloc_slot;
          exec_pid_d  = s_axis_tdata_owner_programID;
        end
      end
      StDispatch: begin
        if (exec_ready) begin
          state_d = StIdle;
          total_d = total_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      busy_d[alloc_slot]    = 1'b1;
      rd_mask_d[alloc_slot] = s_axis_tdata_read_dependencies;
      wr_mask_d[alloc_slot] = s_axis_tdata_write_dependencies;
    end
    if (cmpl_ok) begin
      busy_d[cmpl_slot]    = 1'b0;
      rd_mask_d[cmpl_slot] = '0;
      wr_mask_d[cmpl_slot] = '0;
    end
    if (wd_fire) begin
      busy_d[wd_slot]    = 1'b0;
      rd_mask_d[wd_slot] = '0;
      wr_mask_d[wd_slot] = '0;
    end
    if (cmpl_valid && !cmpl_ok) begin
      err_d = 1'b1;
    end

    inflight_d = inflight_q + 32'(accept) - 32'(cmpl_ok) - 32'(wd_fire);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      busy_q      <= '0;
      exec_slot_q <= '0;
      exec_pid_q  <= '0;
      inflight_q  <= '0;
      total_q     <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        rd_mask_q[i] <= '0;
        wr_mask_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      exec_slot_q <= exec_slot_d;
      exec_pid_q  <= exec_pid_d;
      inflight_q  <= inflight_d;
      total_q     <= total_d;
      err_q       <= err_d;
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        rd_mask_q[i] <= rd_mask_d[i];
        wr_mask_q[i] <= wr_mask_d[i];
      end
    end
  end

  always_comb begin
    locked_read_mask  = '0;
    locked_write_mask = '0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      if (busy_q[i]) begin
        locked_read_mask  = locked_read_mask | rd_mask_q[i];
        locked_write_mask = locked_write_mask | wr_mask_q[i];
      end
    end
  end

  assign exec_valid        = (state_q == StDispatch);
  assign exec_slot         = exec_slot_q;
  assign exec_programID    = exec_pid_q;
  assign inflight_count    = inflight_q;
  assign dispatched_total  = total_q;
  assign err_spurious_cmpl = err_q;

endmodule

// File: doc/txn_dispatcher.md
Name: txn_dispatcher

Overview:
- Consumer at the far end of the insertion queue's output stream.
- Accepts non-conflicting transactions, assigns each one a free executor slot and presents it on a dispatch handshake.
- Holds each slot's read/write dependency masks until the executor returns a completion for that slot.
- Exports the OR of all in-flight masks as lock vectors for the conflict checker.

Parameters:
- MAX_DEPENDENCIES, 256, width of read/write dependency bitmaps.
- NUM_SLOTS, 4, number of in-flight executor slots (2..16).
- SLOT_W, 2, slot index width; must equal clog2(NUM_SLOTS).
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_axis_tvalid  in  1  upstream transaction valid
- s_axis_tready  out  1  upstream ready
- s_axis_tdata_owner_programID  in  64  program ID
- s_axis_tdata_read_dependencies  in  MAX_DEPENDENCIES  read bitmap
- s_axis_tdata_write_dependencies  in  MAX_DEPENDENCIES  write bitmap
- exec_valid  out  1  dispatch request
- exec_ready  in  1  executor accepts dispatch
- exec_slot  out  SLOT_W  slot assigned to the transaction
- exec_programID  out  64  program ID being dispatched
- cmpl_valid  in  1  completion strobe (cmpl_ready is implicitly always 1)
- cmpl_slot  in  SLOT_W  slot being completed
- locked_read_mask  out  MAX_DEPENDENCIES  OR of read masks of busy slots
- locked_write_mask  out  MAX_DEPENDENCIES  OR of write masks of busy slots
- inflight_count  out  32  number of busy slots
- dispatched_total  out  32  completed dispatch handshakes, wraps at 2^32
- err_spurious_cmpl  out  1  sticky flag

Behaviour:
- Reset values:
  - exec_valid=0, exec_slot=0, exec_programID=0.
  - All slots free; all slot masks 0, so both locked masks read 0.
  - inflight_count=0, dispatched_total=0, err_spurious_cmpl=0, FSM=IDLE.
- s_axis_tready: combinational; equals (state==IDLE) && (at least one free slot).
- FSM:
  - IDLE: on s_axis_tvalid && s_axis_tready:
    - Allocate the lowest-index free slot; mark it busy.
    - Write both dependency masks into that slot.
    - Register the program ID and slot onto exec_programID/exec_slot; set exec_valid=1.
    - inflight_count+1; go to DISPATCH.
  - DISPATCH: hold exec_valid, exec_slot and exec_programID stable until exec_ready. On exec_valid && exec_ready: exec_valid=0, dispatched_total+1, go to IDLE.
  - Latency: accept in cycle N gives exec_valid=1 in cycle N+1. At most one accept every 2 cycles.
- Completion:
  - Valid completion = cmpl_valid && slot[cmpl_slot] busy && not (state==DISPATCH && cmpl_slot==exec_slot).
  - A valid completion clears the slot's busy bit and masks at the next edge; inflight_count-1.
  - Any other cmpl_valid (slot free, or slot still awaiting dispatch) is ignored and sets err_spurious_cmpl=1. The flag clears only on reset.
  - cmpl_slot >= NUM_SLOTS is treated as spurious.
- Simultaneous events:
  - Accept and valid completion in the same cycle: both apply, inflight_count unchanged.
  - The freed slot is not reallocatable in that same cycle; allocation uses the pre-edge free vector.
- Locked masks: combinational OR over busy slots. Visible the cycle after accept; cleared the cycle after completion.
- Full: all slots busy, so s_axis_tready=0. Ready reasserts the cycle after a valid completion, if the FSM is in IDLE.
- Reset mid-operation: all state is cleared; in-flight transactions are discarded and exec_valid drops immediately.

Optional Feature:
- Macro: TXN_DISPATCHER_WATCHDOG_EN.
- When defined:
  - Each busy, dispatched slot has an age counter, cleared at dispatch and incremented every cycle.
  - When a counter reaches TIMEOUT_CYCLES, the slot is force-freed exactly as for a valid completion.
  - A one-cycle output pulse watchdog_fire (1 bit) is raised, and watchdog_slot (SLOT_W) reports the slot.
  - If a completion arrives for a slot in the same cycle as its timeout, it counts as a normal completion, with no fire pulse.
- When undefined: no counters, no watchdog ports; slots are freed only by completion.

Test Plan:
- Single txn: programID=0x11, read=bit3, write=bit7; exec_ready=1. Expect:
  - exec_valid in the cycle after accept, exec_slot=0.
  - locked_write_mask=bit7 until cmpl_slot=0, then 0.
  - dispatched_total=1.
- Fill: 5 back-to-back txns, no completions. Expect:
  - Slots 0,1,2,3 assigned in order.
  - s_axis_tready=0 after the 4th; inflight_count=4.
  - After cmpl_slot=2, the 5th txn gets slot 2.
- Backpressure: exec_ready=0 for 10 cycles. Expect exec_valid, exec_slot and exec_programID held constant, and s_axis_tready=0 throughout.
- Spurious completion: cmpl_valid with cmpl_slot=3 while slot 3 is free. Expect err_spurious_cmpl=1, with inflight_count and masks unchanged.
- Simultaneous: slots 0..3 busy, then a completion of slot 1 and a new upstream valid in the same cycle. Expect:
  - No accept in that cycle.
  - Accept on the next cycle into slot 1; inflight_count back to 4.
- Reset during DISPATCH: assert rst_n low. Expect exec_valid=0 asynchronously, locked masks 0 and inflight_count=0.
